// File: rtl/mc_ctrl_pkg.sv
// rtl/mc_ctrl_pkg.sv - shared encodings for the multi-cycle control unit
package mc_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;

    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_SLT  = 6'b101010;
    localparam logic [5:0] FN_MULT = 6'b011000;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    localparam logic [1:0] REG_DST_RT  = 2'b00;
    localparam logic [1:0] REG_DST_RD  = 2'b01;
    localparam logic [1:0] REG_DST_R31 = 2'b10;

    localparam logic [1:0] M2R_ALU = 2'b00;
    localparam logic [1:0] M2R_MDR = 2'b01;
    localparam logic [1:0] M2R_PC  = 2'b10;
    localparam logic [1:0] M2R_MUL = 2'b11;

    localparam logic [1:0] SRCB_RT     = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] IMM_SIGN = 2'b00;
    localparam logic [1:0] IMM_ZERO = 2'b01;
    localparam logic [1:0] IMM_LUI  = 2'b10;

    // All 16 codes of the 4-bit debug encoding are in use. Writeback of
    // ALU and MULT results share S_R_WB, and J/JAL share S_JUMP; the IR
    // (opcode/funct) is stable throughout an instruction and tells them apart.
    typedef enum logic [3:0] {
        S_RESET    = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_EXEC_R   = 4'd3,
        S_R_WB     = 4'd4,
        S_EXEC_I   = 4'd5,
        S_IMM_WB   = 4'd6,
        S_MEM_ADDR = 4'd7,
        S_MEM_RD   = 4'd8,
        S_MEM_WB   = 4'd9,
        S_MEM_WR   = 4'd10,
        S_BRANCH   = 4'd11,
        S_JUMP     = 4'd12,
        S_MUL      = 4'd13,
        S_MUL_WAIT = 4'd14,
        S_ILLEGAL  = 4'd15
    } state_e;

endpackage

// File: rtl/mc_alu_decoder.sv
// rtl/mc_alu_decoder.sv - funct/opcode to alu_op and imm_ext decoder
module mc_alu_decoder
    import mc_ctrl_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output logic [3:0] alu_op,
    output logic [1:0] imm_ext,
    output logic       funct_legal
);

    // R-type selects by funct, I-type by opcode; anything else falls back to ADD
    always_comb begin
        alu_op      = ALU_ADD;
        imm_ext     = IMM_SIGN;
        funct_legal = 1'b0;
        if (opcode == OP_RTYPE) begin
            case (funct)
                FN_ADD: begin alu_op = ALU_ADD; funct_legal = 1'b1; end
                FN_SUB: begin alu_op = ALU_SUB; funct_legal = 1'b1; end
                FN_AND: begin alu_op = ALU_AND; funct_legal = 1'b1; end
                FN_OR:  begin alu_op = ALU_OR;  funct_legal = 1'b1; end
                FN_SLT: begin alu_op = ALU_SLT; funct_legal = 1'b1; end
                default: ;
            endcase
        end else begin
            case (opcode)
                OP_ANDI: begin alu_op = ALU_AND; imm_ext = IMM_ZERO; end
                OP_ORI:  begin alu_op = ALU_OR;  imm_ext = IMM_ZERO; end
                OP_LUI:  begin alu_op = ALU_ADD; imm_ext = IMM_LUI;  end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/mc_control_unit.sv
// rtl/mc_control_unit.sv - multi-cycle FSM controller; MC_CTRL_TRAP_EN makes illegal opcodes halt
module mc_control_unit
    import mc_ctrl_pkg::*;
#(
    parameter int MUL_LATENCY = 4,
    parameter int CNT_W       = 4,
    parameter int ALU_OP_W    = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [5:0]          opcode,
    input  logic [5:0]          funct,
    input  logic                mem_ready,
    output logic                pc_write,
    output logic                pc_write_cond,
    output logic                ir_write,
    output logic                iord,
    output logic                mem_read,
    output logic                mem_write,
    output logic                reg_write,
    output logic [1:0]          reg_dst,
    output logic [1:0]          mem_to_reg,
    output logic                alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic [1:0]          imm_ext,
    output logic [1:0]          pc_src,
    output logic                mul_start,
    output logic                illegal_instr,
    output logic [3:0]          state_dbg
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       alu_op_n;
    logic [3:0]       dec_alu_op;
    logic [1:0]       dec_imm_ext;
    logic             dec_funct_legal;

    mc_alu_decoder u_alu_decoder (
        .opcode      (opcode),
        .funct       (funct),
        .alu_op      (dec_alu_op),
        .imm_ext     (dec_imm_ext),
        .funct_legal (dec_funct_legal)
    );

    assign alu_op    = ALU_OP_W'(alu_op_n);
    assign state_dbg = state_q;

    // State and multiply countdown registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_RESET;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state selection and per-state datapath controls
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        ir_write      = 1'b0;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        reg_write     = 1'b0;
        reg_dst       = REG_DST_RT;
        mem_to_reg    = M2R_ALU;
        alu_src_a     = 1'b0;
        alu_src_b     = SRCB_RT;
        alu_op_n      = ALU_AND;
        imm_ext       = IMM_SIGN;
        pc_src        = PCSRC_ALU;
        mul_start     = 1'b0;
        illegal_instr = 1'b0;

        case (state_q)
            S_RESET: state_d = S_FETCH;

            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = SRCB_FOUR;
                alu_op_n  = ALU_ADD;
                // PC and IR only advance on the cycle the fetch completes
                ir_write  = mem_ready;
                pc_write  = mem_ready;
                if (mem_ready) state_d = S_DECODE;
            end

            S_DECODE: begin
                alu_src_b = SRCB_IMM_SH;
                alu_op_n  = ALU_ADD;
                case (opcode)
                    OP_RTYPE:                      state_d = (funct == FN_MULT) ? S_MUL : S_EXEC_R;
                    OP_LW, OP_SW:                  state_d = S_MEM_ADDR;
                    OP_BEQ:                        state_d = S_BRANCH;
                    OP_J, OP_JAL:                  state_d = S_JUMP;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_LUI: state_d = S_EXEC_I;
                    default:                       state_d = S_ILLEGAL;
                endcase
            end

            S_EXEC_R: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_RT;
                alu_op_n  = dec_alu_op;
                state_d   = dec_funct_legal ? S_R_WB : S_ILLEGAL;
            end

            S_R_WB: begin
                reg_write  = 1'b1;
                reg_dst    = REG_DST_RD;
                mem_to_reg = (funct == FN_MULT) ? M2R_MUL : M2R_ALU;
                state_d    = S_FETCH;
            end

            S_EXEC_I: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                alu_op_n  = dec_alu_op;
                imm_ext   = dec_imm_ext;
                state_d   = S_IMM_WB;
            end

            S_IMM_WB: begin
                reg_write = 1'b1;
                imm_ext   = dec_imm_ext;
                state_d   = S_FETCH;
            end

            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                alu_op_n  = ALU_ADD;
                state_d   = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
            end

            S_MEM_RD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
                if (mem_ready) state_d = S_MEM_WB;
            end

            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = M2R_MDR;
                state_d    = S_FETCH;
            end

            S_MEM_WR: begin
                mem_write = 1'b1;
                iord      = 1'b1;
                if (mem_ready) state_d = S_FETCH;
            end

            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_src_b     = SRCB_RT;
                alu_op_n      = ALU_SUB;
                pc_write_cond = 1'b1;
                pc_src        = PCSRC_ALUOUT;
                state_d       = S_FETCH;
            end

            S_JUMP: begin
                pc_write = 1'b1;
                pc_src   = PCSRC_JUMP;
                if (opcode == OP_JAL) begin
                    reg_write  = 1'b1;
                    reg_dst    = REG_DST_R31;
                    mem_to_reg = M2R_PC;
                end
                state_d = S_FETCH;
            end

            S_MUL: begin
                mul_start = 1'b1;
                cnt_d     = CNT_W'(MUL_LATENCY);
                state_d   = S_MUL_WAIT;
            end

            S_MUL_WAIT: begin
                // Leaving on a count of 1 gives exactly MUL_LATENCY wait cycles
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) state_d = S_R_WB;
            end

            S_ILLEGAL: begin
`ifdef MC_CTRL_TRAP_EN
                illegal_instr = 1'b1;
                state_d       = S_ILLEGAL;
`else
                state_d       = S_FETCH;
`endif
            end

            default: state_d = S_RESET;
        endcase
    end

endmodule

// File: tb/tb_mc_control_unit.sv
// tb/tb_mc_control_unit.sv - scoreboard bench for mc_control_unit
module tb_mc_control_unit;

`ifdef MC_CTRL_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       ir_write;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [3:0] alu_op;
        logic [1:0] imm_ext;
        logic [1:0] pc_src;
        logic       mul_start;
        logic       illegal_instr;
    } rec_t;

    localparam int P_RST = 0, P_FETCH = 1, P_DECODE = 2, P_EXR = 3, P_RWB = 4, P_EXI = 5,
                   P_IWB = 6, P_MADDR = 7, P_MRD = 8, P_LWB = 9, P_MWR = 10, P_BR = 11,
                   P_J = 12, P_JAL = 13, P_MUL = 14, P_MWAIT = 15, P_MULWB = 16, P_ILL = 17;

    logic clk = 1'b0, rst_a = 1'b0, rst_b = 1'b0, mem_ready = 1'b0;
    logic [5:0] opcode = '0, funct = '0;

    logic a_pc_write, a_pc_write_cond, a_ir_write, a_iord, a_mem_read, a_mem_write, a_reg_write;
    logic a_alu_src_a, a_mul_start, a_illegal_instr;
    logic [1:0] a_reg_dst, a_mem_to_reg, a_alu_src_b, a_imm_ext, a_pc_src;
    logic [3:0] a_alu_op, a_state_dbg;
    logic b_pc_write, b_pc_write_cond, b_ir_write, b_iord, b_mem_read, b_mem_write, b_reg_write;
    logic b_alu_src_a, b_mul_start, b_illegal_instr;
    logic [1:0] b_reg_dst, b_mem_to_reg, b_alu_src_b, b_imm_ext, b_pc_src;
    logic [3:0] b_alu_op, b_state_dbg;

    rec_t act_a, act_b, mon_exp, mon_act;
    int   mon_ph;
    rec_t expq[$];
    int   phq[$];
    int   n_pass = 0, n_total = 0;
    int   lat = 4;
    bit   sel = 1'b0;

    always #5 clk = ~clk;

    mc_control_unit #(.MUL_LATENCY(4), .CNT_W(4), .ALU_OP_W(4)) dut_a (
        .clk(clk), .rst_n(rst_a), .opcode(opcode), .funct(funct), .mem_ready(mem_ready),
        .pc_write(a_pc_write), .pc_write_cond(a_pc_write_cond), .ir_write(a_ir_write),
        .iord(a_iord), .mem_read(a_mem_read), .mem_write(a_mem_write), .reg_write(a_reg_write),
        .reg_dst(a_reg_dst), .mem_to_reg(a_mem_to_reg), .alu_src_a(a_alu_src_a),
        .alu_src_b(a_alu_src_b), .alu_op(a_alu_op), .imm_ext(a_imm_ext), .pc_src(a_pc_src),
        .mul_start(a_mul_start), .illegal_instr(a_illegal_instr), .state_dbg(a_state_dbg)
    );

    mc_control_unit #(.MUL_LATENCY(1), .CNT_W(4), .ALU_OP_W(4)) dut_b (
        .clk(clk), .rst_n(rst_b), .opcode(opcode), .funct(funct), .mem_ready(mem_ready),
        .pc_write(b_pc_write), .pc_write_cond(b_pc_write_cond), .ir_write(b_ir_write),
        .iord(b_iord), .mem_read(b_mem_read), .mem_write(b_mem_write), .reg_write(b_reg_write),
        .reg_dst(b_reg_dst), .mem_to_reg(b_mem_to_reg), .alu_src_a(b_alu_src_a),
        .alu_src_b(b_alu_src_b), .alu_op(b_alu_op), .imm_ext(b_imm_ext), .pc_src(b_pc_src),
        .mul_start(b_mul_start), .illegal_instr(b_illegal_instr), .state_dbg(b_state_dbg)
    );

    assign act_a = {a_pc_write, a_pc_write_cond, a_ir_write, a_iord, a_mem_read, a_mem_write,
                    a_reg_write, a_reg_dst, a_mem_to_reg, a_alu_src_a, a_alu_src_b, a_alu_op,
                    a_imm_ext, a_pc_src, a_mul_start, a_illegal_instr};
    assign act_b = {b_pc_write, b_pc_write_cond, b_ir_write, b_iord, b_mem_read, b_mem_write,
                    b_reg_write, b_reg_dst, b_mem_to_reg, b_alu_src_a, b_alu_src_b, b_alu_op,
                    b_imm_ext, b_pc_src, b_mul_start, b_illegal_instr};

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_total++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %h, want %h (dut %0d, t=%0t)", name, got, want, sel, $time);
    endtask

    function automatic string pname(input int p);
        case (p)
            P_RST: return "reset";       P_FETCH: return "fetch";    P_DECODE: return "decode";
            P_EXR: return "exec_r";      P_RWB: return "alu_wb";     P_EXI: return "exec_i";
            P_IWB: return "imm_wb";      P_MADDR: return "mem_addr"; P_MRD: return "mem_rd";
            P_LWB: return "mem_wb";      P_MWR: return "mem_wr";     P_BR: return "branch";
            P_J: return "jump";          P_JAL: return "jal";        P_MUL: return "mul";
            P_MWAIT: return "mul_wait";  P_MULWB: return "mul_wb";   default: return "illegal";
        endcase
    endfunction

    // Reference: what the controller must drive in each step of an instruction
    function automatic rec_t expect_for(input int ph, input logic [5:0] op,
                                        input logic [5:0] fn, input logic mr);
        rec_t r;
        r = '0;
        case (ph)
            P_FETCH:  begin r.mem_read = 1; r.alu_src_b = 2'b01; r.alu_op = 4'b0010;
                            r.ir_write = mr; r.pc_write = mr; end
            P_DECODE: begin r.alu_src_b = 2'b11; r.alu_op = 4'b0010; end
            P_EXR: begin
                r.alu_src_a = 1;
                case (fn)
                    6'b100000: r.alu_op = 4'b0010;
                    6'b100010: r.alu_op = 4'b0110;
                    6'b100100: r.alu_op = 4'b0000;
                    6'b100101: r.alu_op = 4'b0001;
                    default:   r.alu_op = 4'b0111;
                endcase
            end
            P_RWB:    begin r.reg_write = 1; r.reg_dst = 2'b01; end
            P_EXI, P_IWB: begin
                if (ph == P_EXI) begin r.alu_src_a = 1; r.alu_src_b = 2'b10; end
                else r.reg_write = 1;
                case (op)
                    6'b001100: begin r.imm_ext = 2'b01; r.alu_op = (ph == P_EXI) ? 4'b0000 : 4'b0000; end
                    6'b001101: begin r.imm_ext = 2'b01; if (ph == P_EXI) r.alu_op = 4'b0001; end
                    6'b001111: begin r.imm_ext = 2'b10; if (ph == P_EXI) r.alu_op = 4'b0010; end
                    default:   begin if (ph == P_EXI) r.alu_op = 4'b0010; end
                endcase
            end
            P_MADDR:  begin r.alu_src_a = 1; r.alu_src_b = 2'b10; r.alu_op = 4'b0010; end
            P_MRD:    begin r.mem_read = 1; r.iord = 1; end
            P_LWB:    begin r.reg_write = 1; r.mem_to_reg = 2'b01; end
            P_MWR:    begin r.mem_write = 1; r.iord = 1; end
            P_BR:     begin r.alu_src_a = 1; r.alu_op = 4'b0110; r.pc_write_cond = 1; r.pc_src = 2'b01; end
            P_J:      begin r.pc_write = 1; r.pc_src = 2'b10; end
            P_JAL:    begin r.pc_write = 1; r.pc_src = 2'b10; r.reg_write = 1;
                            r.reg_dst = 2'b10; r.mem_to_reg = 2'b10; end
            P_MUL:    r.mul_start = 1;
            P_MULWB:  begin r.reg_write = 1; r.reg_dst = 2'b01; r.mem_to_reg = 2'b11; end
            P_ILL:    r.illegal_instr = TRAP;
            default:  ;
        endcase
        return r;
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    // Drive one clock cycle of inputs and queue the outputs expected for it
    task automatic step(input int ph, input logic [5:0] op, input logic [5:0] fn, input logic mr);
        @(posedge clk); #1;
        opcode = op; funct = fn; mem_ready = mr;
        expq.push_back(expect_for(ph, op, fn, mr));
        phq.push_back(ph);
    endtask

    task automatic reset_low();
        opcode = '0; funct = '0; mem_ready = 1'b0;
        if (sel) rst_b = 1'b0; else rst_a = 1'b0;
        #1;
        chk("reset_outputs_zero", 32'(sel ? act_b : act_a), 32'd0);
        chk("reset_state_dbg", 32'(sel ? b_state_dbg : a_state_dbg), 32'd0);
    endtask

    task automatic reset_release();
        @(posedge clk); #1;
        if (sel) rst_b = 1'b1; else rst_a = 1'b1;
        expq.push_back(expect_for(P_RST, 6'd0, 6'd0, 1'b0));
        phq.push_back(P_RST);
        chk("released_state_dbg", 32'(sel ? b_state_dbg : a_state_dbg), 32'd0);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset_low();
        reset_release();
    endtask

    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int nf, input int nm);
        repeat (nf) step(P_FETCH, op, fn, 1'b0);
        step(P_FETCH, op, fn, 1'b1);
        step(P_DECODE, op, fn, rb());
        case (op)
            6'b000000: begin
                if (fn == 6'b011000) begin
                    step(P_MUL, op, fn, rb());
                    for (int i = 0; i < lat; i++) step(P_MWAIT, op, fn, rb());
                    step(P_MULWB, op, fn, rb());
                end else begin
                    step(P_EXR, op, fn, rb());
                    step(P_RWB, op, fn, rb());
                end
            end
            6'b100011: begin
                step(P_MADDR, op, fn, rb());
                repeat (nm) step(P_MRD, op, fn, 1'b0);
                step(P_MRD, op, fn, 1'b1);
                step(P_LWB, op, fn, rb());
            end
            6'b101011: begin
                step(P_MADDR, op, fn, rb());
                repeat (nm) step(P_MWR, op, fn, 1'b0);
                step(P_MWR, op, fn, 1'b1);
            end
            6'b000100: step(P_BR, op, fn, rb());
            6'b000010: step(P_J, op, fn, rb());
            6'b000011: step(P_JAL, op, fn, rb());
            6'b001000, 6'b001100, 6'b001101, 6'b001111: begin
                step(P_EXI, op, fn, rb());
                step(P_IWB, op, fn, rb());
            end
            default: begin
                step(P_ILL, op, fn, rb());
                if (TRAP) begin
                    repeat (3) step(P_ILL, op, fn, rb());
                    do_reset();
                end
            end
        endcase
    endtask

    task automatic run_random(input int n);
        logic [5:0] fns[6]  = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b011000};
        logic [5:0] ills[4] = '{6'b111111, 6'b000001, 6'b000101, 6'b100000};
        logic [5:0] ops[9]  = '{6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b000011,
                                6'b001000, 6'b001100, 6'b001101, 6'b001111};
        for (int k = 0; k < n; k++) begin
            int r = $urandom_range(0, 13);
            int nf = $urandom_range(0, 2);
            int nm = $urandom_range(0, 3);
            if (r < 4)       run_instr(6'b000000, fns[$urandom_range(0, 5)], nf, nm);
            else if (r == 13) run_instr(ills[$urandom_range(0, 3)], 6'($urandom), nf, nm);
            else             run_instr(ops[r - 4], 6'($urandom), nf, nm);
        end
    endtask

    // Monitor: one expected record per cycle, compared away from the active edge
    always @(negedge clk) begin
        if (expq.size() > 0) begin
            mon_exp = expq.pop_front();
            mon_ph  = phq.pop_front();
            mon_act = sel ? act_b : act_a;
            chk($sformatf("cycle_%s", pname(mon_ph)), 32'(mon_act), 32'(mon_exp));
            chk("single_write_strobe", 32'(mon_act.reg_write & mon_act.mem_write), 32'd0);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "bench did not complete");
    end

    initial begin
        do_reset();
        run_instr(6'b000000, 6'b100000, 0, 0);   // ADD
        run_instr(6'b100011, 6'd0, 0, 3);        // LW with 3 memory stall cycles
        run_instr(6'b000011, 6'd0, 0, 0);        // JAL
        run_instr(6'b000000, 6'b011000, 0, 0);   // MULT, latency 4
        run_instr(6'b111111, 6'd0, 0, 0);        // illegal opcode
        run_instr(6'b000000, 6'b100010, 2, 0);   // SUB after fetch stalls
        // SW interrupted by reset while waiting on memory
        step(P_FETCH, 6'b101011, 6'd0, 1'b1);
        step(P_DECODE, 6'b101011, 6'd0, 1'b1);
        step(P_MADDR, 6'b101011, 6'd0, 1'b1);
        step(P_MWR, 6'b101011, 6'd0, 1'b0);
        step(P_MWR, 6'b101011, 6'd0, 1'b0);
        @(negedge clk); #2;
        reset_low();
        reset_release();
        run_random(60);

        @(posedge clk); #1;
        rst_a = 1'b0;
        sel = 1'b1;
        lat = 1;
        do_reset();
        run_instr(6'b000000, 6'b011000, 0, 0);   // MULT, latency 1
        run_instr(6'b000000, 6'b100101, 1, 0);
        run_instr(6'b000000, 6'b011000, 2, 0);
        run_random(15);

        @(posedge clk); @(negedge clk); #1;
        chk("scoreboard_drained", 32'(expq.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
